lab_stats_accum: RTL and testbench
==================================

// Module: lab_stats_accum
// PURPOSE
//  Streams lab pixels (3+13 signed fixed point) from the RGB-to-lab stage and accumulates per-channel statistics over one frame.
//  Produces the per-channel mean and variance that the colour-transfer scaling stage consumes.
//  Sits directly downstream of the RGB-to-lab converter and registers its combinational outputs at the accept handshake.
// PARAMETERS
//  LOG2_N   16   frame size = 2**LOG2_N pixels; valid range 1..16
// PORTS
//  i_clk       in   1        clock, rising edge
//  i_rst       in   1        reset, asynchronous, active-low
//  i_start     in   1        1-cycle pulse: clear accumulators, begin a frame
//  i_valid     in   1        pixel on i_l/i_a/i_b is valid
//  i_l,i_a,i_b in   16 each  signed Q3.13 lab pixel
//  o_ready     out  1        block accepts a pixel this cycle
//  o_busy      out  1        frame in progress (state != IDLE)
//  o_done      out  1        1-cycle pulse: stats valid
//  o_mean_l/a/b out 16 each  signed Q3.13 mean
//  o_var_l/a/b  out 32 each  unsigned Q6.26 variance
// BEHAVIOUR
//  Reset (i_rst=0, async): state=IDLE; all outputs 0; counters and accumulators 0.
//  FSM: IDLE -> ACCUM on i_start. ACCUM -> FIN0 after last accept. FIN0 -> FIN1 -> FIN2 -> DONE. DONE -> IDLE after 1 cycle.
//  Handshake: o_ready = (state==ACCUM). A pixel is accepted on a clock edge where i_valid && o_ready.
//   i_valid gaps are allowed; inputs are sampled only on accept.
//  Counter: LOG2_N-bit, incremented per accept. The accept with count == 2**LOG2_N-1 is the last; the counter wraps to 0.
//  Sums: sum_x is signed, 16+LOG2_N bits. sq_x is unsigned, 32+LOG2_N bits, and accumulates x*x as Q6.26.
//   No overflow is possible at these widths.
//  Mean: on the edge leaving ACCUM, o_mean_x <= sum_x >>> LOG2_N (arithmetic shift; truncates toward -inf).
//  FINk (k=0:l, 1:a, 2:b): one shared 16x16 signed squarer computes m2 = mean_k*mean_k.
//   o_var_k <= (sq_k >> LOG2_N) - m2.
//   If the result is negative (truncation artefact), clamp it to 0. The result is truncated to 32 bits.
//  DONE: o_done=1 for exactly one cycle. Mean/var outputs hold until the next i_start is accepted in IDLE.
//   The next i_start clears the outputs to 0 on the same edge that clears the accumulators.
//  Latency: o_done is high in the 4th cycle after the last-accept edge.
//  i_start while o_busy=1: ignored.
//  i_start and i_valid in the same IDLE cycle: the pixel is not accepted (o_ready=0 in IDLE).
//  Reset mid-frame: immediate return to IDLE with all state cleared; no o_done.
// CONFIGURATION
//  Macro LAB_STATS_VAR_EN.
//  Defined: behaviour as above.
//  Undefined:
//   - no square accumulators, squarer or FIN states;
//   - ACCUM -> DONE directly; o_done is high 1 cycle after the last accept;
//   - o_var_l/a/b are tied to 0.
// STRUCTURE
//  Shared header lab_defs.vh holds:
//   - LAB_W=16, LAB_FRAC=13, VAR_W=32;
//   - state encodings IDLE, ACCUM, FIN0, FIN1, FIN2, DONE (3-bit localparams).
//  Sub-module lab_stat_channel (instantiated x3): holds one channel's sum/sq accumulators, clear and accept enables, and the mean shift.
//  Top level holds the FSM, counter and shared squarer/variance datapath.
// TESTING
//  Bench uses LOG2_N=2 (4-pixel frames) unless noted.
//  1. Start; 4x (l=0x2000, a=0xE000, b=0x0000) -> mean_l=0x2000, mean_a=0xE000, mean_b=0, all var=0, o_done after 4 cycles.
//  2. l=0x2000,0x6000,0x2000,0x6000 -> mean_l=0x4000, var_l=0x0400_0000 (1.0).
//  3. Four pixels with random i_valid gaps -> results equal the gap-free run; o_ready=0 in every non-ACCUM cycle.
//  4. All channels 0x8000 (-4.0) -> mean=0x8000, var=0; sq sums reach 4*0x4000_0000 without overflow.
//  5. i_start pulsed during ACCUM and FIN1 -> ignored; exactly one o_done per frame.
//  6. i_rst low after 2 accepts -> outputs 0, IDLE; a new frame then gives correct stats.
//   Also rerun test 1 with LAB_STATS_VAR_EN undefined: var=0 and o_done 1 cycle after the last accept.

Source files
------------

// File: rtl/lab_stats_accum_pkg.sv
// lab_stats_accum_pkg: shared widths and FSM state encoding for the lab
// statistics accumulator (lab_stats_accum and its per-channel slices).
// The FIN states are only used when LAB_STATS_VAR_EN is defined.
package lab_stats_accum_pkg;

  // Lab samples are signed Q3.13.
  localparam int LAB_W    = 16;
  localparam int LAB_FRAC = 13;

  // Squared samples keep both integer and fraction bits doubled: Q6.26.
  localparam int VAR_W = 2 * (LAB_W - LAB_FRAC) + 2 * LAB_FRAC;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    FIN0  = 3'd2,
    FIN1  = 3'd3,
    FIN2  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // E[x^2] - mean^2 can dip below zero because both terms are truncated;
  // the sign bit of the widened difference selects a clamp to zero.
  function automatic logic [VAR_W-1:0] clamp_var(input logic [VAR_W:0] diff);
    return diff[VAR_W] ? '0 : diff[VAR_W-1:0];
  endfunction

endpackage

// File: rtl/lab_stats_accum_channel.sv
// lab_stats_accum_channel: one lab channel's running sum (and, with
// LAB_STATS_VAR_EN defined, running sum of squares). o_mean is the mean that
// results if the current pixel is accepted, so the top can capture it on the
// same edge as the last accept.
module lab_stats_accum_channel
  import lab_stats_accum_pkg::*;
#(
  parameter int LOG2_N = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_acc,
  input  logic [LAB_W-1:0] i_x,
  output logic [LAB_W-1:0] o_mean
`ifdef LAB_STATS_VAR_EN
  ,
  output logic [VAR_W-1:0] o_sq_mean
`endif
);

  localparam int SUM_W = LAB_W + LOG2_N;

  logic [SUM_W-1:0] sum_reg;
  logic [SUM_W-1:0] sum_next;

  assign sum_next = sum_reg + {{LOG2_N{i_x[LAB_W-1]}}, i_x};

  // Arithmetic shift right by LOG2_N, truncated to LAB_W: the top LAB_W bits.
  assign o_mean = sum_next[LOG2_N +: LAB_W];

  // Signed running sum, cleared at frame start.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sum_reg <= '0;
    end else if (i_clr) begin
      sum_reg <= '0;
    end else if (i_acc) begin
      sum_reg <= sum_next;
    end
  end

`ifdef LAB_STATS_VAR_EN
  localparam int SQ_W = VAR_W + LOG2_N;

  logic signed [VAR_W-1:0] x_ext;
  logic [VAR_W-1:0]        x_sq;
  logic [SQ_W-1:0]         sq_reg;

  assign x_ext = {{(VAR_W - LAB_W){i_x[LAB_W-1]}}, i_x};
  assign x_sq  = x_ext * x_ext;

  // Unsigned Q6.26 running sum of squares; it is final once ACCUM ends.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sq_reg <= '0;
    end else if (i_clr) begin
      sq_reg <= '0;
    end else if (i_acc) begin
      sq_reg <= sq_reg + {{LOG2_N{1'b0}}, x_sq};
    end
  end

  assign o_sq_mean = sq_reg[LOG2_N +: VAR_W];
`endif

endmodule

// File: rtl/lab_stats_accum.sv
// lab_stats_accum: per-frame mean and variance of the l/a/b channels of a
// stream of Q3.13 lab pixels. 2**LOG2_N accepted pixels form one frame.
// Optional feature macro: LAB_STATS_VAR_EN. When undefined, no square sums,
// no squarer, no FIN states; o_done follows the last accept by one cycle and
// the variance outputs are tied to zero.
module lab_stats_accum
  import lab_stats_accum_pkg::*;
#(
  parameter int LOG2_N = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [LAB_W-1:0] i_l,
  input  logic [LAB_W-1:0] i_a,
  input  logic [LAB_W-1:0] i_b,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [LAB_W-1:0] o_mean_l,
  output logic [LAB_W-1:0] o_mean_a,
  output logic [LAB_W-1:0] o_mean_b,
  output logic [VAR_W-1:0] o_var_l,
  output logic [VAR_W-1:0] o_var_a,
  output logic [VAR_W-1:0] o_var_b
);

  state_t            state;
  logic [LOG2_N-1:0] count;
  logic              accept;
  logic              last_accept;
  logic              clear;

  logic [LAB_W-1:0] x_arr         [3];
  logic [LAB_W-1:0] mean_next_arr [3];
  logic [LAB_W-1:0] mean_reg      [3];

  assign x_arr[0] = i_l;
  assign x_arr[1] = i_a;
  assign x_arr[2] = i_b;

  assign accept      = i_valid && (state == ACCUM);
  assign last_accept = accept && (count == '1);
  assign clear       = i_start && (state == IDLE);

  assign o_ready = (state == ACCUM);
  assign o_busy  = (state != IDLE);
  assign o_done  = (state == DONE);

  assign o_mean_l = mean_reg[0];
  assign o_mean_a = mean_reg[1];
  assign o_mean_b = mean_reg[2];

`ifdef LAB_STATS_VAR_EN
  logic [VAR_W-1:0]        sq_mean_arr [3];
  logic [VAR_W-1:0]        var_reg     [3];
  logic [1:0]              fin_idx;
  logic [LAB_W-1:0]        fin_mean;
  logic signed [VAR_W-1:0] mean_ext;
  logic [VAR_W-1:0]        m2;
  logic [VAR_W-1:0]        var_calc;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      lab_stats_accum_channel #(
        .LOG2_N(LOG2_N)
      ) u_chan (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (clear),
        .i_acc  (accept),
        .i_x    (x_arr[gi]),
        .o_mean (mean_next_arr[gi])
`ifdef LAB_STATS_VAR_EN
        ,
        .o_sq_mean(sq_mean_arr[gi])
`endif
      );
    end
  endgenerate

`ifdef LAB_STATS_VAR_EN
  // Pick the channel whose variance is finished in the current FIN state.
  always_comb begin
    fin_idx = 2'd0;
    case (state)
      FIN1:    fin_idx = 2'd1;
      FIN2:    fin_idx = 2'd2;
      default: fin_idx = 2'd0;
    endcase
  end

  // One shared squarer serves all three channels, one per FIN cycle.
  assign fin_mean = mean_reg[fin_idx];
  assign mean_ext = {{(VAR_W - LAB_W){fin_mean[LAB_W-1]}}, fin_mean};
  assign m2       = mean_ext * mean_ext;
  assign var_calc = clamp_var({1'b0, sq_mean_arr[fin_idx]} - {1'b0, m2});

  assign o_var_l = var_reg[0];
  assign o_var_a = var_reg[1];
  assign o_var_b = var_reg[2];
`else
  assign o_var_l = '0;
  assign o_var_a = '0;
  assign o_var_b = '0;
`endif

  // Frame sequencing, pixel counter and result registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= IDLE;
      count <= '0;
      for (int i = 0; i < 3; i++) begin
        mean_reg[i] <= '0;
`ifdef LAB_STATS_VAR_EN
        var_reg[i]  <= '0;
`endif
      end
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= ACCUM;
            count <= '0;
            for (int i = 0; i < 3; i++) begin
              mean_reg[i] <= '0;
`ifdef LAB_STATS_VAR_EN
              var_reg[i]  <= '0;
`endif
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            count <= count + LOG2_N'(1);
            if (last_accept) begin
              for (int i = 0; i < 3; i++) begin
                mean_reg[i] <= mean_next_arr[i];
              end
`ifdef LAB_STATS_VAR_EN
              state <= FIN0;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef LAB_STATS_VAR_EN
        FIN0: begin
          var_reg[0] <= var_calc;
          state      <= FIN1;
        end
        FIN1: begin
          var_reg[1] <= var_calc;
          state      <= FIN2;
        end
        FIN2: begin
          var_reg[2] <= var_calc;
          state      <= DONE;
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lab_stats_accum.sv
// tb_lab_stats_accum: randomized frames against a plain-arithmetic model of
// the per-frame mean/variance, 4-pixel frames (LOG2_N=2).
// Honours LAB_STATS_VAR_EN the same way as the design.
module tb_lab_stats_accum;

  localparam int NPIX = 4;
`ifdef LAB_STATS_VAR_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic        i_valid;
  logic [15:0] i_l, i_a, i_b;
  logic        o_ready, o_busy, o_done;
  logic [15:0] o_mean_l, o_mean_a, o_mean_b;
  logic [31:0] o_var_l, o_var_a, o_var_b;

  int errors = 0;
  int checks = 0;
  int frame_no = 0;

  logic [15:0] pix [3][NPIX];

  lab_stats_accum #(.LOG2_N(2)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_start (i_start),
    .i_valid (i_valid),
    .i_l     (i_l),
    .i_a     (i_a),
    .i_b     (i_b),
    .o_ready (o_ready),
    .o_busy  (o_busy),
    .o_done  (o_done),
    .o_mean_l(o_mean_l),
    .o_mean_a(o_mean_a),
    .o_mean_b(o_mean_b),
    .o_var_l (o_var_l),
    .o_var_a (o_var_a),
    .o_var_b (o_var_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (frame %0d)", tag, got, exp, frame_no);
    end
  endtask

  // Mean = floor(sum / N); variance = floor(sum of squares / N) - mean^2,
  // floored at zero, all in ordinary integer arithmetic.
  function automatic void calc(input int ch, output logic [15:0] m, output logic [31:0] v);
    int     s, xi, mfl;
    longint q, e, vv;
    s = 0;
    q = 0;
    for (int i = 0; i < NPIX; i++) begin
      xi = int'($signed(pix[ch][i]));
      s += xi;
      q += longint'(xi) * longint'(xi);
    end
    mfl = (s - (((s % NPIX) + NPIX) % NPIX)) / NPIX;
    m   = 16'(mfl);
    e   = q / NPIX;
    vv  = e - longint'(mfl) * longint'(mfl);
    if (vv < 0) vv = 0;
    v = 32'(vv);
`ifndef LAB_STATS_VAR_EN
    v = 32'd0;
`endif
  endfunction

  task automatic set_chan(input int ch, input logic [15:0] v0, input logic [15:0] v1,
                          input logic [15:0] v2, input logic [15:0] v3);
    pix[ch][0] = v0;
    pix[ch][1] = v1;
    pix[ch][2] = v2;
    pix[ch][3] = v3;
  endtask

  task automatic rand_pix();
    for (int ch = 0; ch < 3; ch++)
      for (int i = 0; i < NPIX; i++)
        pix[ch][i] = 16'($urandom);
  endtask

  // One frame: start pulse, four accepts (optionally with gaps, a stray
  // start, a junk pixel alongside start, or a reset after abort_at accepts).
  task automatic run_frame(input bit gaps, input bit glitch, input bit junk, input int abort_at);
    logic [15:0] em [3];
    logic [31:0] ev [3];
    int n, guard;
    frame_no++;
    for (int ch = 0; ch < 3; ch++) calc(ch, em[ch], ev[ch]);

    @(negedge clk);
    check("idle_ready", {31'd0, o_ready}, 32'd0);
    i_start = 1'b1;
    if (junk) begin
      i_valid = 1'b1;
      i_l = 16'($urandom);
      i_a = 16'($urandom);
      i_b = 16'($urandom);
    end
    @(negedge clk);
    i_start = 1'b0;
    i_valid = 1'b0;
    check("start_busy", {31'd0, o_busy}, 32'd1);
    check("start_clr_mean_l", {16'd0, o_mean_l}, 32'd0);
    check("start_clr_var_b", o_var_b, 32'd0);

    n = 0;
    guard = 0;
    while (n < NPIX && guard < 100) begin
      guard++;
      check("accum_ready", {31'd0, o_ready}, 32'd1);
      if (gaps && $urandom_range(0, 2) == 0) begin
        i_valid = 1'b0;
        i_l = 16'($urandom);
        i_a = 16'($urandom);
        i_b = 16'($urandom);
      end else begin
        i_valid = 1'b1;
        i_l = pix[0][n];
        i_a = pix[1][n];
        i_b = pix[2][n];
      end
      if (glitch && n == 2) i_start = 1'b1;
      @(posedge clk);
      if (i_valid) n++;
      @(negedge clk);
      i_valid = 1'b0;
      i_start = 1'b0;
      if (abort_at > 0 && n == abort_at) begin
        i_rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_ready", {31'd0, o_ready}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_mean_a", {16'd0, o_mean_a}, 32'd0);
        check("rst_var_l", o_var_l, 32'd0);
        @(negedge clk);
        i_rst = 1'b1;
        $display("frame %0d: reset after %0d accepts", frame_no, n);
        return;
      end
    end
    check("accept_count", n, NPIX);

    for (int c = 1; c <= LAT; c++) begin
      check("fin_ready", {31'd0, o_ready}, 32'd0);
      check("fin_busy", {31'd0, o_busy}, 32'd1);
      check("done_timing", {31'd0, o_done}, {31'd0, c == LAT});
      i_start = (glitch && c == 2);
      if (c < LAT) @(negedge clk);
    end
    i_start = 1'b0;

    check("mean_l", {16'd0, o_mean_l}, {16'd0, em[0]});
    check("mean_a", {16'd0, o_mean_a}, {16'd0, em[1]});
    check("mean_b", {16'd0, o_mean_b}, {16'd0, em[2]});
    check("var_l", o_var_l, ev[0]);
    check("var_a", o_var_a, ev[1]);
    check("var_b", o_var_b, ev[2]);

    @(negedge clk);
    check("done_once", {31'd0, o_done}, 32'd0);
    check("back_idle", {31'd0, o_busy}, 32'd0);
    check("idle_ready_after", {31'd0, o_ready}, 32'd0);
    check("hold_mean_l", {16'd0, o_mean_l}, {16'd0, em[0]});
    check("hold_var_a", o_var_a, ev[1]);
    $display("frame %0d: mean=%h/%h/%h var=%h/%h/%h", frame_no,
             o_mean_l, o_mean_a, o_mean_b, o_var_l, o_var_a, o_var_b);
  endtask

  initial begin
    i_rst   = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b0;
    i_l = 16'd0;
    i_a = 16'd0;
    i_b = 16'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_ready", {31'd0, o_ready}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    check("reset_mean_l", {16'd0, o_mean_l}, 32'd0);
    check("reset_var_l", o_var_l, 32'd0);
    i_rst = 1'b1;

    // Constant channels.
    set_chan(0, 16'h2000, 16'h2000, 16'h2000, 16'h2000);
    set_chan(1, 16'hE000, 16'hE000, 16'hE000, 16'hE000);
    set_chan(2, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    run_frame(1'b0, 1'b0, 1'b0, 0);

    // Unit variance on l.
    set_chan(0, 16'h2000, 16'h6000, 16'h2000, 16'h6000);
    set_chan(1, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    set_chan(2, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    run_frame(1'b0, 1'b0, 1'b0, 0);

    // Same data with and without valid gaps.
    rand_pix();
    run_frame(1'b0, 1'b0, 1'b0, 0);
    run_frame(1'b1, 1'b0, 1'b0, 0);

    // Most negative sample everywhere.
    for (int ch = 0; ch < 3; ch++) set_chan(ch, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
    run_frame(1'b0, 1'b0, 1'b0, 0);

    // Stray start pulses during ACCUM and FIN1.
    rand_pix();
    run_frame(1'b1, 1'b1, 1'b0, 0);

    // Reset mid-frame, then a full frame.
    rand_pix();
    run_frame(1'b0, 1'b0, 1'b0, 2);
    rand_pix();
    run_frame(1'b0, 1'b0, 1'b0, 0);

    // Truncation makes mean^2 exceed E[x^2]: clamp to zero; junk pixel with start.
    set_chan(0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    set_chan(1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
    set_chan(2, 16'h0001, 16'h0000, 16'h0003, 16'h0000);
    run_frame(1'b0, 1'b0, 1'b1, 0);

    // Random frames with random gaps and junk-at-start.
    for (int k = 0; k < 6; k++) begin
      rand_pix();
      run_frame(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
